// File: rtl/id_stage_hs_if.sv
// ============================================================================
// Module   : id_stage_hs_if
// Brief    : IF -> ID valid/ready handshake bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface id_stage_hs_if;
   logic        in_valid;
   logic        id_ready;
   logic [31:0] instruction;
   logic [31:0] next_i_addr;

   modport master (output in_valid, output instruction, output next_i_addr, input id_ready);
   modport slave  (input in_valid, input instruction, input next_i_addr, output id_ready);
endinterface

`default_nettype wire

// File: rtl/id_stage_hs.sv
// ============================================================================
// Module   : id_stage_hs
// Brief    : MIPS decode stage with valid/ready handshake, forwarding and counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_stage_hs #(
   parameter int XLEN      = 32,
   parameter int REG_AW    = 5,
   parameter int FWD_N     = 2,
   parameter int SEL_W     = $clog2(FWD_N + 1),
   parameter int WR_BYPASS = 1,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   id_stage_hs_if.slave          hs,
   input  logic                  reg_write,
   input  logic [REG_AW-1:0]     wreg_addr,
   input  logic [XLEN-1:0]       wreg_data,
   input  logic [SEL_W-1:0]      rs_fwd_sel,
   input  logic [SEL_W-1:0]      rt_fwd_sel,
   input  logic [FWD_N*XLEN-1:0] fwd_val,
   input  logic                  hazard,
   input  logic                  flush,
   input  logic                  ex_ready,
   input  logic                  cnt_clr,
   output logic [REG_AW-1:0]     id_rs,
   output logic [REG_AW-1:0]     id_rt,
   output logic [5:0]            id_opcode,
   output logic                  id_rt_is_source,
   output logic [1:0]            if_pc_source,
   output logic [31:0]           branch_addr,
   output logic [31:0]           jump_addr,
   output logic                  ID_EX_valid,
   output logic [XLEN-1:0]       ID_EX_A,
   output logic [XLEN-1:0]       ID_EX_B,
   output logic [REG_AW-1:0]     ID_EX_rs,
   output logic [REG_AW-1:0]     ID_EX_rt,
   output logic [REG_AW-1:0]     ID_EX_rd,
   output logic [5:0]            ID_EX_opcode,
   output logic [XLEN-1:0]       ID_EX_imm,
   output logic [8:0]            ID_EX_ctrl,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      bubble_cnt
);
   localparam int NREG = 2 ** REG_AW;

   logic [XLEN-1:0]   r_regs [NREG];
   logic [31:0]       w_instr;
   logic [REG_AW-1:0] w_rs, w_rt, w_rd;
   logic [XLEN-1:0]   w_rs_rf, w_rt_rf, w_a, w_b, w_imm;
   logic              w_branch_eq, w_load, w_id_ready, w_enter_valid;
   logic [1:0]        w_pc_src, w_alu_op;
   logic              w_rt_src, w_imm_cmd, w_alu_src_b, w_dst_sel;
   logic              w_mem_rd, w_mem_wr, w_mem_to_reg, w_reg_wr;
   logic [8:0]        w_ctrl;

   logic              r_valid;
   logic [XLEN-1:0]   r_a, r_b, r_imm;
   logic [REG_AW-1:0] r_rs, r_rt, r_rd;
   logic [5:0]        r_opcode;
   logic [8:0]        r_ctrl;
   logic [CNT_W-1:0]  r_stall_cnt, r_bubble_cnt;

   assign w_instr = hs.instruction;
   assign w_rs    = w_instr[21 +: REG_AW];
   assign w_rt    = w_instr[16 +: REG_AW];
   assign w_rd    = w_instr[11 +: REG_AW];
   assign w_imm   = {{(XLEN-16){w_instr[15]}}, w_instr[15:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (reg_write && wreg_addr != '0) begin
         r_regs[wreg_addr] <= wreg_data;
      end
   end

   generate
      if (WR_BYPASS != 0) begin : g_bypass
         assign w_rs_rf = (w_rs == '0) ? '0 :
                          (reg_write && wreg_addr == w_rs) ? wreg_data : r_regs[w_rs];
         assign w_rt_rf = (w_rt == '0) ? '0 :
                          (reg_write && wreg_addr == w_rt) ? wreg_data : r_regs[w_rt];
      end else begin : g_no_bypass
         assign w_rs_rf = (w_rs == '0) ? '0 : r_regs[w_rs];
         assign w_rt_rf = (w_rt == '0) ? '0 : r_regs[w_rt];
      end
   endgenerate

   // Select values above FWD_N fall through to zero.
   always_comb begin
      w_a = '0;
      w_b = '0;
      if (rs_fwd_sel == '0) w_a = w_rs_rf;
      if (rt_fwd_sel == '0) w_b = w_rt_rf;
      for (int k = 1; k <= FWD_N; k++) begin
         if (rs_fwd_sel == SEL_W'(k)) w_a = fwd_val[(k-1)*XLEN +: XLEN];
         if (rt_fwd_sel == SEL_W'(k)) w_b = fwd_val[(k-1)*XLEN +: XLEN];
      end
   end

   assign w_branch_eq = (w_a == w_b);

   control u_control (
      .opcode          (w_instr[31:26]),
      .branch_eq       (w_branch_eq),
      .if_pc_source    (w_pc_src),
      .id_rt_is_source (w_rt_src),
      .ex_imm_command  (w_imm_cmd),
      .ex_alu_src_b    (w_alu_src_b),
      .ex_dst_reg_sel  (w_dst_sel),
      .ex_alu_op       (w_alu_op),
      .mem_read        (w_mem_rd),
      .mem_write       (w_mem_wr),
      .wb_mem_to_reg   (w_mem_to_reg),
      .wb_reg_write    (w_reg_wr)
   );

   assign w_ctrl = {w_reg_wr, w_mem_to_reg, w_mem_rd, w_mem_wr,
                    w_imm_cmd, w_alu_src_b, w_dst_sel, w_alu_op};

   assign w_load        = !r_valid || ex_ready;
   assign w_id_ready    = w_load && hs.in_valid && !hazard;
   assign w_enter_valid = hs.in_valid && !hazard && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_rs     <= '0;
         r_rt     <= '0;
         r_rd     <= '0;
         r_opcode <= '0;
         r_imm    <= '0;
         r_ctrl   <= '0;
      end else if (w_load) begin
         r_valid  <= w_enter_valid;
         r_a      <= w_a;
         r_b      <= w_b;
         r_rs     <= w_rs;
         r_rt     <= w_rt;
         r_rd     <= w_rd;
         r_opcode <= w_instr[31:26];
         r_imm    <= w_imm;
         // A null instruction or any bubble carries no side effects downstream.
         r_ctrl   <= (w_enter_valid && w_instr != 32'h0) ? w_ctrl : 9'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (hs.in_valid && !w_id_ready && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_load && hs.in_valid && hazard && r_bubble_cnt != '1)
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
   end

   assign hs.id_ready       = w_id_ready;
   assign id_rs             = w_rs;
   assign id_rt             = w_rt;
   assign id_opcode         = w_instr[31:26];
   assign id_rt_is_source   = w_rt_src;
   assign if_pc_source      = w_enter_valid && w_load ? w_pc_src : 2'b00;
   assign branch_addr       = hs.next_i_addr + {{14{w_instr[15]}}, w_instr[15:0], 2'b00};
   assign jump_addr         = {hs.next_i_addr[31:28], w_instr[25:0], 2'b00};
   assign ID_EX_valid       = r_valid;
   assign ID_EX_A           = r_a;
   assign ID_EX_B           = r_b;
   assign ID_EX_rs          = r_rs;
   assign ID_EX_rt          = r_rt;
   assign ID_EX_rd          = r_rd;
   assign ID_EX_opcode      = r_opcode;
   assign ID_EX_imm         = r_imm;
   assign ID_EX_ctrl        = r_ctrl;
   assign stall_cnt         = r_stall_cnt;
   assign bubble_cnt        = r_bubble_cnt;
endmodule

// ============================================================================
// Module   : control
// Brief    : MIPS opcode decoder producing pipeline control signals.
// Revision : 1.0
// ============================================================================
module control (
   input  logic [5:0] opcode,
   input  logic       branch_eq,
   output logic [1:0] if_pc_source,
   output logic       id_rt_is_source,
   output logic       ex_imm_command,
   output logic       ex_alu_src_b,
   output logic       ex_dst_reg_sel,
   output logic [1:0] ex_alu_op,
   output logic       mem_read,
   output logic       mem_write,
   output logic       wb_mem_to_reg,
   output logic       wb_reg_write
);
   localparam logic [5:0] c_op_rtype = 6'h00;
   localparam logic [5:0] c_op_j     = 6'h02;
   localparam logic [5:0] c_op_beq   = 6'h04;
   localparam logic [5:0] c_op_bne   = 6'h05;
   localparam logic [5:0] c_op_addi  = 6'h08;
   localparam logic [5:0] c_op_lw    = 6'h23;
   localparam logic [5:0] c_op_sw    = 6'h2B;

   always_comb begin
      if_pc_source    = 2'b00;
      id_rt_is_source = 1'b0;
      ex_imm_command  = 1'b0;
      ex_alu_src_b    = 1'b0;
      ex_dst_reg_sel  = 1'b0;
      ex_alu_op       = 2'b00;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      wb_mem_to_reg   = 1'b0;
      wb_reg_write    = 1'b0;
      case (opcode)
         c_op_rtype: begin
            id_rt_is_source = 1'b1;
            ex_dst_reg_sel  = 1'b1;
            ex_alu_op       = 2'b10;
            wb_reg_write    = 1'b1;
         end
         c_op_j:    if_pc_source = 2'b10;
         c_op_beq: begin
            id_rt_is_source = 1'b1;
            ex_alu_op       = 2'b01;
            if_pc_source    = branch_eq ? 2'b01 : 2'b00;
         end
         c_op_bne: begin
            id_rt_is_source = 1'b1;
            ex_alu_op       = 2'b01;
            if_pc_source    = branch_eq ? 2'b00 : 2'b01;
         end
         c_op_addi: begin
            ex_imm_command = 1'b1;
            ex_alu_src_b   = 1'b1;
            wb_reg_write   = 1'b1;
         end
         c_op_lw: begin
            ex_alu_src_b  = 1'b1;
            mem_read      = 1'b1;
            wb_mem_to_reg = 1'b1;
            wb_reg_write  = 1'b1;
         end
         c_op_sw: begin
            id_rt_is_source = 1'b1;
            ex_alu_src_b    = 1'b1;
            mem_write       = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

`default_nettype wire

// File: tb/tb_id_stage_hs.sv
// ============================================================================
// Module   : tb_id_stage_hs
// Brief    : Directed bench for id_stage_hs (bypassing and non-bypassing copies).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_stage_hs;
   localparam int XLEN  = 32;
   localparam int AW    = 5;
   localparam int FN    = 3;
   localparam int SW    = 2;
   localparam int CW    = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [31:0]     instruction, next_i_addr;
   logic            reg_write;
   logic [AW-1:0]   wreg_addr;
   logic [XLEN-1:0] wreg_data;
   logic [SW-1:0]   rs_fwd_sel, rt_fwd_sel;
   logic [FN*XLEN-1:0] fwd_val;
   logic            hazard, flush, ex_ready, cnt_clr;

   logic [AW-1:0]   id_rs, id_rt, ex_rs, ex_rt, ex_rd;
   logic [5:0]      id_opcode, ex_opcode;
   logic            id_rt_is_source, ex_valid;
   logic [1:0]      if_pc_source;
   logic [31:0]     branch_addr, jump_addr;
   logic [XLEN-1:0] ex_a, ex_b, ex_imm;
   logic [8:0]      ex_ctrl;
   logic [CW-1:0]   stall_cnt, bubble_cnt;

   logic [AW-1:0]   n_id_rs, n_id_rt, n_ex_rs, n_ex_rt, n_ex_rd;
   logic [5:0]      n_id_opcode, n_ex_opcode;
   logic            n_rt_src, n_ex_valid;
   logic [1:0]      n_pc_src;
   logic [31:0]     n_branch_addr, n_jump_addr;
   logic [XLEN-1:0] n_ex_a, n_ex_b, n_ex_imm;
   logic [8:0]      n_ex_ctrl;
   logic [CW-1:0]   n_stall_cnt, n_bubble_cnt;

   int checks = 0;
   int errors = 0;

   id_stage_hs_if hs0 ();
   id_stage_hs_if hs1 ();

   assign hs0.in_valid    = in_valid;
   assign hs0.instruction = instruction;
   assign hs0.next_i_addr = next_i_addr;
   assign hs1.in_valid    = in_valid;
   assign hs1.instruction = instruction;
   assign hs1.next_i_addr = next_i_addr;

   always #5 clk = ~clk;

   id_stage_hs #(.XLEN(XLEN), .REG_AW(AW), .FWD_N(FN), .WR_BYPASS(1), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .hs(hs0),
      .reg_write(reg_write), .wreg_addr(wreg_addr), .wreg_data(wreg_data),
      .rs_fwd_sel(rs_fwd_sel), .rt_fwd_sel(rt_fwd_sel), .fwd_val(fwd_val),
      .hazard(hazard), .flush(flush), .ex_ready(ex_ready), .cnt_clr(cnt_clr),
      .id_rs(id_rs), .id_rt(id_rt), .id_opcode(id_opcode),
      .id_rt_is_source(id_rt_is_source), .if_pc_source(if_pc_source),
      .branch_addr(branch_addr), .jump_addr(jump_addr),
      .ID_EX_valid(ex_valid), .ID_EX_A(ex_a), .ID_EX_B(ex_b),
      .ID_EX_rs(ex_rs), .ID_EX_rt(ex_rt), .ID_EX_rd(ex_rd),
      .ID_EX_opcode(ex_opcode), .ID_EX_imm(ex_imm), .ID_EX_ctrl(ex_ctrl),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   id_stage_hs #(.XLEN(XLEN), .REG_AW(AW), .FWD_N(FN), .WR_BYPASS(0), .CNT_W(CW)) dut_nb (
      .clk(clk), .rst(rst), .hs(hs1),
      .reg_write(reg_write), .wreg_addr(wreg_addr), .wreg_data(wreg_data),
      .rs_fwd_sel(rs_fwd_sel), .rt_fwd_sel(rt_fwd_sel), .fwd_val(fwd_val),
      .hazard(hazard), .flush(flush), .ex_ready(ex_ready), .cnt_clr(cnt_clr),
      .id_rs(n_id_rs), .id_rt(n_id_rt), .id_opcode(n_id_opcode),
      .id_rt_is_source(n_rt_src), .if_pc_source(n_pc_src),
      .branch_addr(n_branch_addr), .jump_addr(n_jump_addr),
      .ID_EX_valid(n_ex_valid), .ID_EX_A(n_ex_a), .ID_EX_B(n_ex_b),
      .ID_EX_rs(n_ex_rs), .ID_EX_rt(n_ex_rt), .ID_EX_rd(n_ex_rd),
      .ID_EX_opcode(n_ex_opcode), .ID_EX_imm(n_ex_imm), .ID_EX_ctrl(n_ex_ctrl),
      .stall_cnt(n_stall_cnt), .bubble_cnt(n_bubble_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; instruction = '0; next_i_addr = '0;
      reg_write = 1'b0; wreg_addr = '0; wreg_data = '0;
      rs_fwd_sel = '0; rt_fwd_sel = '0; fwd_val = '0;
      hazard = 1'b0; flush = 1'b0; ex_ready = 1'b1; cnt_clr = 1'b0;
      tick();
      tick();
      check("rst_valid",  {31'b0, ex_valid}, 32'h0);
      check("rst_ctrl",   {23'b0, ex_ctrl}, 32'h0);
      check("rst_a",      ex_a, 32'h0);
      check("rst_stall",  {16'b0, stall_cnt}, 32'h0);
      check("rst_bubble", {16'b0, bubble_cnt}, 32'h0);

      // WB writes r5 = 0x1234
      rst = 1'b0; reg_write = 1'b1; wreg_addr = 5'd5; wreg_data = 32'h1234;
      tick();
      reg_write = 1'b0;

      // add r3,r5,r0
      in_valid = 1'b1; instruction = 32'h00A01820; next_i_addr = 32'h4;
      #1;
      check("add_id_ready", {31'b0, hs0.id_ready}, 32'h1);
      check("add_id_rs", {27'b0, id_rs}, 32'd5);
      tick();
      check("add_valid", {31'b0, ex_valid}, 32'h1);
      check("add_A", ex_a, 32'h1234);
      check("add_ctrl", {23'b0, ex_ctrl}, 32'h106);
      check("add_rd", {27'b0, ex_rd}, 32'd3);
      check("add_imm", ex_imm, 32'h1820);

      // add r1,r7,r0 while WB writes r7 in the same cycle
      instruction = 32'h00E00820;
      reg_write = 1'b1; wreg_addr = 5'd7; wreg_data = 32'hA5A5;
      tick();
      reg_write = 1'b0;
      check("bypass_A", ex_a, 32'hA5A5);
      check("nobypass_A", n_ex_a, 32'h0);

      // add r2,r0,r9 with forwarding: rs<-source0, rt<-source2
      instruction = 32'h00091020;
      fwd_val = {32'hDEAD, 32'h1111, 32'h2222};
      rs_fwd_sel = 2'd1; rt_fwd_sel = 2'd3;
      tick();
      check("fwd_B_src2", ex_b, 32'hDEAD);
      check("fwd_A_src0", ex_a, 32'h2222);
      rs_fwd_sel = 2'd0; rt_fwd_sel = 2'd0;

      // write to r0 must not bypass nor stick
      instruction = 32'h00002020;
      reg_write = 1'b1; wreg_addr = 5'd0; wreg_data = 32'hFFFF;
      tick();
      reg_write = 1'b0;
      check("r0_bypass_A", ex_a, 32'h0);
      check("r0_bypass_B", ex_b, 32'h0);
      tick();
      check("r0_after_write", ex_a, 32'h0);

      // EX back-pressure for 4 cycles
      ex_ready = 1'b0; instruction = 32'h00E00820;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("stall_id_ready", {31'b0, hs0.id_ready}, 32'h0);
         tick();
         check("stall_hold_rd", {27'b0, ex_rd}, 32'd4);
         check("stall_hold_valid", {31'b0, ex_valid}, 32'h1);
      end
      check("stall_cnt4", {16'b0, stall_cnt}, 32'd4);
      check("stall_bubble0", {16'b0, bubble_cnt}, 32'd0);

      // one-cycle hazard: bubble enters, instruction held
      ex_ready = 1'b1; hazard = 1'b1;
      #1;
      check("haz_id_ready", {31'b0, hs0.id_ready}, 32'h0);
      tick();
      check("haz_valid", {31'b0, ex_valid}, 32'h0);
      check("haz_ctrl", {23'b0, ex_ctrl}, 32'h0);
      check("haz_bubble_cnt", {16'b0, bubble_cnt}, 32'd1);
      check("haz_stall_cnt", {16'b0, stall_cnt}, 32'd5);
      hazard = 1'b0;
      #1;
      check("post_haz_ready", {31'b0, hs0.id_ready}, 32'h1);
      tick();
      check("post_haz_valid", {31'b0, ex_valid}, 32'h1);
      check("post_haz_A", ex_a, 32'hA5A5);
      check("post_haz_ctrl", {23'b0, ex_ctrl}, 32'h106);

      // clear wins over a simultaneous stall increment
      ex_ready = 1'b0; cnt_clr = 1'b1;
      tick();
      check("clr_stall", {16'b0, stall_cnt}, 32'd0);
      check("clr_bubble", {16'b0, bubble_cnt}, 32'd0);
      cnt_clr = 1'b0; ex_ready = 1'b1;

      // beq r0,r0,-1 at next_i_addr 0x100
      instruction = 32'h1000FFFF; next_i_addr = 32'h100;
      #1;
      check("beq_branch_addr", branch_addr, 32'hFC);
      check("beq_jump_addr", jump_addr, 32'h0003FFFC);
      check("beq_pc_src", {30'b0, if_pc_source}, 32'h1);
      check("beq_rt_src", {31'b0, id_rt_is_source}, 32'h1);
      flush = 1'b1;
      #1;
      check("flush_pc_src", {30'b0, if_pc_source}, 32'h0);
      check("flush_id_ready", {31'b0, hs0.id_ready}, 32'h1);
      tick();
      check("flush_valid", {31'b0, ex_valid}, 32'h0);
      check("flush_ctrl", {23'b0, ex_ctrl}, 32'h0);

      // flush and hazard together: held, bubble enters
      hazard = 1'b1;
      #1;
      check("fh_id_ready", {31'b0, hs0.id_ready}, 32'h0);
      tick();
      check("fh_valid", {31'b0, ex_valid}, 32'h0);
      check("fh_bubble_cnt", {16'b0, bubble_cnt}, 32'd1);
      check("fh_stall_cnt", {16'b0, stall_cnt}, 32'd1);
      hazard = 1'b0; flush = 1'b0;

      // reset mid-transfer drops ID_EX and clears the regfile
      instruction = 32'h00A01820; next_i_addr = 32'h4;
      tick();
      check("pre_rst_valid", {31'b0, ex_valid}, 32'h1);
      check("pre_rst_A", ex_a, 32'h1234);
      rst = 1'b1;
      tick();
      check("mid_rst_valid", {31'b0, ex_valid}, 32'h0);
      check("mid_rst_ctrl", {23'b0, ex_ctrl}, 32'h0);
      check("mid_rst_stall", {16'b0, stall_cnt}, 32'd0);
      rst = 1'b0;
      tick();
      check("post_rst_regfile_A", ex_a, 32'h0);
      check("post_rst_valid", {31'b0, ex_valid}, 32'h1);

      in_valid = 1'b0;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
